// File: rtl/wallace_tree_16_16.sv
// Registered Wallace-tree reduction for the 16x16 radix-4 Booth multiplier: eight aligned 32-bit
// partial products are compressed to a sum/carry pair, and their carry-propagate sum is registered.
module wallace_tree_16_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] booth_in0,
   input  logic [31:0] booth_in1,
   input  logic [31:0] booth_in2,
   input  logic [31:0] booth_in3,
   input  logic [31:0] booth_in4,
   input  logic [31:0] booth_in5,
   input  logic [31:0] booth_in6,
   input  logic [31:0] booth_in7,
   output logic [31:0] wallace_sout,
   output logic [31:0] wallace_cout,
   output logic [31:0] add_out
);

   // Carry word is the bitwise majority shifted up one place; bit 31's carry-out is dropped.
   function automatic logic [31:0] csa_sum(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
      return a ^ b ^ c;
   endfunction

   function automatic logic [31:0] csa_carry(input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
      logic [31:0] maj;
      maj = (a & b) | (a & c) | (b & c);
      return {maj[30:0], 1'b0};
   endfunction

   logic [31:0] s1, k1, s2, k2;
   logic [31:0] s3, k3, s4, k4;
   logic [31:0] s5, k5;
   logic [31:0] sout_d, cout_d, add_d;
   logic [31:0] sout_q, cout_q, add_q;

   always_comb begin
      // Level 1: 8 -> 6 words
      s1 = csa_sum(booth_in0, booth_in1, booth_in2);
      k1 = csa_carry(booth_in0, booth_in1, booth_in2);
      s2 = csa_sum(booth_in3, booth_in4, booth_in5);
      k2 = csa_carry(booth_in3, booth_in4, booth_in5);
      // Level 2: 6 -> 4 words
      s3 = csa_sum(s1, k1, s2);
      k3 = csa_carry(s1, k1, s2);
      s4 = csa_sum(k2, booth_in6, booth_in7);
      k4 = csa_carry(k2, booth_in6, booth_in7);
      // Level 3: 4 -> 3 words
      s5 = csa_sum(s3, k3, s4);
      k5 = csa_carry(s3, k3, s4);
      // Level 4: 3 -> 2 words, then the final carry-propagate add
      sout_d = csa_sum(s5, k5, k4);
      cout_d = csa_carry(s5, k5, k4);
      add_d  = sout_d + cout_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sout_q <= '0;
         cout_q <= '0;
         add_q  <= '0;
      end else begin
         sout_q <= sout_d;
         cout_q <= cout_d;
         add_q  <= add_d;
      end
   end

   assign wallace_sout = sout_q;
   assign wallace_cout = cout_q;
   assign add_out      = add_q;

endmodule

// File: tb/tb_wallace_tree_16_16.sv
// Directed and streaming checks for wallace_tree_16_16: hand-computed tree outputs, wrap-around,
// signed sums, back-to-back results and asynchronous reset behaviour.
module tb_wallace_tree_16_16;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_v [8];
   logic [31:0] wallace_sout, wallace_cout, add_out;

   int tests_run;
   int tests_failed;

   wallace_tree_16_16 dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .booth_in0    (in_v[0]),
      .booth_in1    (in_v[1]),
      .booth_in2    (in_v[2]),
      .booth_in3    (in_v[3]),
      .booth_in4    (in_v[4]),
      .booth_in5    (in_v[5]),
      .booth_in6    (in_v[6]),
      .booth_in7    (in_v[7]),
      .wallace_sout (wallace_sout),
      .wallace_cout (wallace_cout),
      .add_out      (add_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_all(input logic [31:0] v);
      for (int i = 0; i < 8; i++) in_v[i] = v;
   endtask

   // Drive inputs away from the edge, then sample just after the loading edge.
   task automatic apply_and_check(input string tag, input logic [31:0] exp_s,
                                  input logic [31:0] exp_c, input logic [31:0] exp_a);
      @(posedge clk);
      #1;
      check_eq({tag, ".sout"}, wallace_sout, exp_s);
      check_eq({tag, ".cout"}, wallace_cout, exp_c);
      check_eq({tag, ".add"}, add_out, exp_a);
   endtask

   logic [31:0] prev_sum;
   logic [31:0] cur_sum;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      set_all(32'd0);
      #12;
      check_eq("reset.sout", wallace_sout, 32'd0);
      check_eq("reset.cout", wallace_cout, 32'd0);
      check_eq("reset.add", add_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_and_check("zeros", 32'd0, 32'd0, 32'd0);

      // Fresh reset so the "0 before the edge" check is meaningful.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      set_all(32'd10);
      check_eq("tens.pre_edge", add_out, 32'd0);
      apply_and_check("tens", 32'd40, 32'd40, 32'd80);

      @(negedge clk);
      set_all(32'd0);
      in_v[0] = 32'h1234_5678;
      apply_and_check("single", 32'h1234_5678, 32'd0, 32'h1234_5678);

      @(negedge clk);
      set_all(32'hFFFF_FFFF);
      apply_and_check("all_ones", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFF8);

      @(negedge clk);
      set_all(32'd0);
      in_v[0] = 32'hFFFF_FFFB;
      in_v[1] = 32'd3;
      apply_and_check("signed", 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFE);

      // Streaming: each negedge checks the result of the previous cycle's inputs.
      prev_sum = 32'd0;
      for (int n = 0; n < 24; n++) begin
         @(negedge clk);
         if (n > 0) begin
            check_eq("stream.add", add_out, prev_sum);
            check_eq("stream.cout_b0", {31'd0, wallace_cout[0]}, 32'd0);
         end
         cur_sum = 32'd0;
         for (int i = 0; i < 8; i++) begin
            in_v[i] = $urandom;
            cur_sum = cur_sum + in_v[i];
         end
         prev_sum = cur_sum;
      end

      // Asynchronous reset mid-stream, asserted between edges.
      @(negedge clk);
      check_eq("stream.last", add_out, prev_sum);
      rst_n = 1'b0;
      #1;
      check_eq("async.sout", wallace_sout, 32'd0);
      check_eq("async.cout", wallace_cout, 32'd0);
      check_eq("async.add", add_out, 32'd0);
      @(posedge clk);
      #1;
      check_eq("hold.add", add_out, 32'd0);
      check_eq("hold.sout", wallace_sout, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check_eq("released.pre_edge", add_out, 32'd0);
      set_all(32'd1);
      apply_and_check("post_reset", 32'd4, 32'd4, 32'd8);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
